// File: rtl/key_press_classifier.sv
// Classifies debounced active-low key gestures into short, double and long presses,
// emitting one registered single-cycle pulse per gesture.
module key_press_classifier #(
  parameter int LONG_CYC    = 50_000_000,
  parameter int DBL_GAP_CYC = 12_500_000,
  parameter int CNT_W       = 26
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_n,
  output logic short_p,
  output logic double_p,
  output logic long_p,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HOLD = 3'd2,
    WAIT2     = 3'd3,
    PRESS2    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(DBL_GAP_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               key_d_q, key_d_d;
  logic               short_q, short_d;
  logic               double_q, double_d;
  logic               long_q, long_d;
  logic               busy_q, busy_d;
  logic               press_edge;

  // key_d resets low so a key already held when reset lifts never counts as a press
  assign press_edge = key_d_q & ~key_n;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d_d  = key_n;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (press_edge) begin
          state_d = PRESS1;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS1: begin
        if (key_n) begin
          state_d = WAIT2;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LONG_HOLD: begin
        if (key_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      WAIT2: begin
        // A press landing exactly on the window end starts a fresh gesture
        if (cnt_q == GAP_END) begin
          short_d = 1'b1;
          if (!key_n) begin
            state_d = PRESS1;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (!key_n) begin
          state_d = PRESS2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESS2: begin
        if (key_n) begin
          double_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      key_d_q  <= 1'b0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_d_q  <= key_d_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
    end
  end

  assign short_p  = short_q;
  assign double_p = double_q;
  assign long_p   = long_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// Directed bench for key_press_classifier with short parameters (LONG=20, GAP=10);
// timing checks use hand-computed edge offsets, pulse totals come from a negedge monitor.
module tb_key_press_classifier;

  logic clk;
  logic rstn;
  logic key_n;
  logic short_p, double_p, long_p, busy;

  int total;
  int bad;
  int n_short, n_double, n_long;
  int base_short, base_double, base_long;

  key_press_classifier #(
    .LONG_CYC   (20),
    .DBL_GAP_CYC(10),
    .CNT_W      (8)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .key_n   (key_n),
    .short_p (short_p),
    .double_p(double_p),
    .long_p  (long_p),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulses are high for the whole cycle after their edge, so negedge sees each exactly once
  initial begin
    n_short  = 0;
    n_double = 0;
    n_long   = 0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        n_short  = n_short + int'(short_p);
        n_double = n_double + int'(double_p);
        n_long   = n_long + int'(long_p);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic lvl, input int n);
    key_n = lvl;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic markCounts();
    base_short  = n_short;
    base_double = n_double;
    base_long   = n_long;
  endtask

  task automatic checkCounts(input string tag, input int es, input int ed, input int el);
    checkOutput({tag, "_nshort"}, n_short - base_short, es);
    checkOutput({tag, "_ndouble"}, n_double - base_double, ed);
    checkOutput({tag, "_nlong"}, n_long - base_long, el);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    key_n = 1'b1;
    tick();
    tick();
    checkOutput("rst_short", short_p, 0);
    checkOutput("rst_double", double_p, 0);
    checkOutput("rst_long", long_p, 0);
    checkOutput("rst_busy", busy, 0);
    rstn = 1'b1;
    applyStimulus(1'b1, 3);

    // Short press: low 5, release at R, short_p only after R+10
    markCounts();
    applyStimulus(1'b0, 1);
    checkOutput("s1_busy_press", busy, 1);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput($sformatf("s1_short_R%0d", k), short_p, (k == 10) ? 1 : 0);
    end
    checkOutput("s1_busy_end", busy, 0);
    tick();
    checkOutput("s1_short_gone", short_p, 0);
    applyStimulus(1'b1, 3);
    checkCounts("s1", 1, 0, 0);

    // Double press: low 5, high 4, low 5, release
    markCounts();
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 5);
    checkOutput("s2_busy_p2", busy, 1);
    applyStimulus(1'b1, 1);
    checkOutput("s2_double", double_p, 1);
    checkOutput("s2_busy_end", busy, 0);
    tick();
    checkOutput("s2_double_gone", double_p, 0);
    applyStimulus(1'b1, 12);
    checkCounts("s2", 0, 1, 0);

    // Long press: 30 low samples from P, long_p on P+19 only
    markCounts();
    applyStimulus(1'b0, 1);
    for (int k = 1; k <= 29; k++) begin
      tick();
      if (k >= 17 && k <= 21)
        checkOutput($sformatf("s3_long_P%0d", k), long_p, (k == 19) ? 1 : 0);
    end
    checkOutput("s3_busy_hold", busy, 1);
    applyStimulus(1'b1, 1);
    checkOutput("s3_busy_release", busy, 0);
    applyStimulus(1'b1, 12);
    checkCounts("s3", 0, 0, 1);

    // Key held through reset release: never a gesture
    markCounts();
    key_n = 1'b0;
    rstn  = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    applyStimulus(1'b0, 8);
    checkOutput("s4_busy_low", busy, 0);
    applyStimulus(1'b1, 1);
    checkOutput("s4_busy_rel", busy, 0);
    applyStimulus(1'b1, 12);
    checkOutput("s4_busy_end", busy, 0);
    checkCounts("s4", 0, 0, 0);

    // Gap boundary: second press sampled at R+9 is still a double
    markCounts();
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 1);
    checkOutput("s5a_short_R9", short_p, 0);
    checkOutput("s5a_busy_R9", busy, 1);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 1);
    checkOutput("s5a_double", double_p, 1);
    applyStimulus(1'b1, 12);
    checkCounts("s5a", 0, 1, 0);

    // Gap boundary: press sampled at R+10 emits short_p and starts a new gesture
    markCounts();
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b1, 9);
    applyStimulus(1'b0, 1);
    checkOutput("s5b_short_R10", short_p, 1);
    checkOutput("s5b_busy_R10", busy, 1);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k >= 9)
        checkOutput($sformatf("s5b_short2_R%0d", k), short_p, (k == 10) ? 1 : 0);
    end
    checkOutput("s5b_busy_end", busy, 0);
    applyStimulus(1'b1, 3);
    checkCounts("s5b", 2, 0, 0);

    // Reset pulsed during WAIT2 at R+4 kills the pending short_p
    markCounts();
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b1, 4);
    checkOutput("s6_busy_before", busy, 1);
    rstn = 1'b0;
    #1;
    checkOutput("s6_busy_rst", busy, 0);
    checkOutput("s6_short_rst", short_p, 0);
    tick();
    tick();
    rstn = 1'b1;
    applyStimulus(1'b1, 15);
    checkOutput("s6_busy_end", busy, 0);
    checkCounts("s6", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
